mem_fill_arbiter: RTL and testbench
===================================

// Module: mem_fill_arbiter
// PURPOSE
//   Arbitrates I-cache and D-cache block misses onto the single shared main memory and sequences
//   each block fill. Sits between the Fetch/Memory-stage cache controllers and main memory.
//   Generates per-word fill strobes for the winning cache and the stall signals used by the
//   hazard unit to hold the PC and pipeline registers while a miss is outstanding.
// PARAMETERS
//   MEM_LAT    4   cycles from mem_en/mem_addr to the matching mem_data_valid (pipelined memory)
//   BLK_WORDS  8   16-bit words per cache block (16-byte block); power of two
//   ADDR_W     16  byte-address width
// PORTS
//   clk              in   1       system clock, all state on rising edge
//   rst_n            in   1       asynchronous, active-low reset
//   icache_miss      in   1       I-cache miss pending (level, held until serviced)
//   icache_addr      in   ADDR_W  byte address of I-cache miss
//   dcache_miss      in   1       D-cache miss pending (level, held until serviced)
//   dcache_addr      in   ADDR_W  byte address of D-cache miss
//   mem_data_valid   in   1       main memory returns one word this cycle
//   mem_en           out  1       read request to main memory this cycle
//   mem_addr         out  ADDR_W  word-aligned read address
//   fill_wen         out  1       write returned word into the cache being filled
//   fill_sel_d       out  1       0 = fill targets I-cache, 1 = D-cache
//   fill_word        out  log2(BLK_WORDS)  word index within block for fill_wen
//   fill_done        out  1       one-cycle pulse: last word written, cache writes tag/valid
//   icache_stall     out  1       stall Fetch (PC, instruction fetch)
//   dcache_stall     out  1       stall Memory stage and everything upstream
// BEHAVIOUR
//   Reset: state IDLE, counters 0; mem_en, fill_wen, fill_done, fill_sel_d, stalls all 0,
//     mem_addr 0, fill_word 0. Reset asserted mid-fill aborts immediately; no fill_done issued.
//   States: IDLE -> FILL -> IDLE.
//   IDLE: if dcache_miss, grant D (D has priority: older instruction); else if icache_miss,
//     grant I. On grant latch base = addr & ~(2*BLK_WORDS-1), latch fill_sel_d; go FILL next
//     cycle. No memory request issued in the grant cycle.
//   FILL: issue counter ic (0..BLK_WORDS-1): mem_en=1, mem_addr = base + 2*ic for BLK_WORDS
//     consecutive cycles, then mem_en=0. Return counter rc: each mem_data_valid -> fill_wen=1,
//     fill_word=rc, rc++. Word rc=BLK_WORDS-1 -> fill_done=1 same cycle, state IDLE next.
//     First fill_wen MEM_LAT cycles after first mem_en; fill occupies BLK_WORDS+MEM_LAT cycles
//     after grant (12 at defaults); next grant earliest cycle after fill_done.
//   Counter and address arithmetic is modulo width; base alignment guarantees no block crossing.
//   mem_data_valid in IDLE, or after rc has wrapped, is ignored (no fill_wen).
//   Miss inputs are sampled only in IDLE; deassertion during FILL does not abort the fill.
//   Simultaneous misses: D filled first; I remains pending and is granted on the following IDLE.
//   A new miss on the side just filled in the fill_done cycle is not granted until next IDLE.
//   icache_stall = icache_miss & ~(fill_done & ~fill_sel_d) (combinational).
//   dcache_stall = dcache_miss & ~(fill_done &  fill_sel_d) (combinational).
//   fill_wen, fill_word, fill_done only asserted in FILL.
// TESTING
//   I miss @0x0036 alone -> mem_addr 0x0030..0x003E on 8 cycles, fill_wen idx 0..7, fill_sel_d=0,
//     fill_done 12 cycles after grant, icache_stall drops in that cycle.
//   I and D miss same cycle (I 0x1000, D 0x2004) -> D block 0x2000 filled first, then I 0x1000;
//     icache_stall held high throughout D fill.
//   icache_miss dropped mid-fill (branch mispredict flush) -> fill still completes, 8 fill_wen, fill_done.
//   rst_n low at 5th fill cycle -> all outputs 0 asynchronously, no fill_done; after release
//     pending miss re-granted from word 0.
//   Spurious mem_data_valid in IDLE -> no fill_wen, state stays IDLE.
//   Back-to-back D misses 0x0010 then 0x00F0 -> second grant the cycle after first fill_done,
//     no overlap of mem_en between fills.

Source files
------------

// File: rtl/mem_fill_arbiter.sv
// Shares one pipelined main memory between I-cache and D-cache block misses and runs each block fill.
// It produces the per-word fill strobes and the stalls the hazard unit uses while a miss is outstanding.
module mem_fill_arbiter #(
    parameter int MEM_LAT   = 4,
    parameter int BLK_WORDS = 8,
    parameter int ADDR_W    = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         icache_miss,
    input  logic [ADDR_W-1:0]            icache_addr,
    input  logic                         dcache_miss,
    input  logic [ADDR_W-1:0]            dcache_addr,
    input  logic                         mem_data_valid,
    output logic                         mem_en,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic                         fill_wen,
    output logic                         fill_sel_d,
    output logic [$clog2(BLK_WORDS)-1:0] fill_word,
    output logic                         fill_done,
    output logic                         icache_stall,
    output logic                         dcache_stall,
    output logic [0:0]                   dbg_state_o,
    output logic [$clog2(BLK_WORDS+MEM_LAT+1)-1:0] dbg_fill_cyc_o
);

    localparam int CW   = $clog2(BLK_WORDS);
    localparam int FC_W = $clog2(BLK_WORDS + MEM_LAT + 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_FILL = 1'b1;

    localparam logic [ADDR_W-1:0] OFS_MASK  = ADDR_W'(2 * BLK_WORDS - 1);
    localparam logic [CW:0]       ISSUE_END = (CW + 1)'(BLK_WORDS);
    localparam logic [CW-1:0]     RC_LAST   = CW'(BLK_WORDS - 1);
    localparam logic [FC_W-1:0]   FC_MAX    = '1;

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              sel_q, sel_d;
    logic [CW:0]       ic_q, ic_d;
    logic [CW-1:0]     rc_q, rc_d;
    logic [FC_W-1:0]   fc_q, fc_d;

    logic              grant_any;
    logic [ADDR_W-1:0] grant_addr;

    // Memory protocol: a request is a single-cycle mem_en with mem_addr; memory never
    // back-pressures and answers each request exactly MEM_LAT cycles later with mem_data_valid.
    always_comb begin
        mem_en       = (state_q == ST_FILL) && (ic_q != ISSUE_END);
        mem_addr     = mem_en ? (base_q + ADDR_W'({ic_q[CW-1:0], 1'b0})) : '0;
        fill_wen     = (state_q == ST_FILL) && mem_data_valid;
        fill_word    = fill_wen ? rc_q : '0;
        fill_done    = fill_wen && (rc_q == RC_LAST);
        fill_sel_d   = sel_q;
        icache_stall = icache_miss & ~(fill_done & ~sel_q);
        dcache_stall = dcache_miss & ~(fill_done &  sel_q);
    end

    // D-cache wins ties: its miss belongs to the older instruction in the pipeline.
    always_comb begin
        grant_any  = dcache_miss | icache_miss;
        grant_addr = dcache_miss ? dcache_addr : icache_addr;
    end

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        sel_d   = sel_q;
        ic_d    = ic_q;
        rc_d    = rc_q;
        fc_d    = fc_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_any) begin
                    state_d = ST_FILL;
                    base_d  = grant_addr & ~OFS_MASK;
                    sel_d   = dcache_miss;
                    ic_d    = '0;
                    rc_d    = '0;
                    fc_d    = '0;
                end
            end
            ST_FILL: begin
                if (mem_en) begin
                    ic_d = ic_q + 1'b1;
                end
                if (fc_q != FC_MAX) begin
                    fc_d = fc_q + 1'b1;
                end
                if (fill_wen) begin
                    rc_d = rc_q + 1'b1;
                end
                // Last word returned: the fill is over, misses are looked at again next cycle.
                if (fill_done) begin
                    state_d = ST_IDLE;
                    ic_d    = '0;
                    rc_d    = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            base_q  <= '0;
            sel_q   <= 1'b0;
            ic_q    <= '0;
            rc_q    <= '0;
            fc_q    <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            sel_q   <= sel_d;
            ic_q    <= ic_d;
            rc_q    <= rc_d;
            fc_q    <= fc_d;
        end
    end

    assign dbg_state_o    = state_q;
    assign dbg_fill_cyc_o = fc_q;

endmodule

// File: tb/tb_mem_fill_arbiter.sv
// Directed bench for mem_fill_arbiter with a fixed-latency memory model and hand-derived cycle timing.
module tb_mem_fill_arbiter;

    localparam int LAT = 4;

    logic        clk;
    logic        rst_n;
    logic        icache_miss;
    logic [15:0] icache_addr;
    logic        dcache_miss;
    logic [15:0] dcache_addr;
    logic        mem_data_valid;
    logic        mem_en;
    logic [15:0] mem_addr;
    logic        fill_wen;
    logic        fill_sel_d;
    logic [2:0]  fill_word;
    logic        fill_done;
    logic        icache_stall;
    logic        dcache_stall;
    logic [0:0]  dbg_state;
    logic [3:0]  dbg_fill_cyc;

    logic [LAT-1:0] vpipe;
    logic           spur_valid;

    int checks;
    int errors;

    mem_fill_arbiter #(.MEM_LAT(LAT), .BLK_WORDS(8), .ADDR_W(16)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .icache_miss    (icache_miss),
        .icache_addr    (icache_addr),
        .dcache_miss    (dcache_miss),
        .dcache_addr    (dcache_addr),
        .mem_data_valid (mem_data_valid),
        .mem_en         (mem_en),
        .mem_addr       (mem_addr),
        .fill_wen       (fill_wen),
        .fill_sel_d     (fill_sel_d),
        .fill_word      (fill_word),
        .fill_done      (fill_done),
        .icache_stall   (icache_stall),
        .dcache_stall   (dcache_stall),
        .dbg_state_o    (dbg_state),
        .dbg_fill_cyc_o (dbg_fill_cyc)
    );

    // clock / reset-driven memory model
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vpipe <= '0;
        else        vpipe <= {vpipe[LAT-2:0], mem_en};
    end

    assign mem_data_valid = vpipe[LAT-1] | spur_valid;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        icache_miss = 1'b0; icache_addr = '0;
        dcache_miss = 1'b0; dcache_addr = '0;
        spur_valid = 1'b0;
        step();
        step();
        checks++;
        if ({mem_en, fill_wen, fill_done, fill_sel_d, icache_stall, dcache_stall, dbg_state} !== 7'b0 ||
            mem_addr !== 16'h0 || fill_word !== 3'd0) begin
            errors++;
            $display("FAIL reset_outputs: got en=%b wen=%b done=%b sel=%b ist=%b dst=%b st=%b addr=%h word=%0d, want all 0",
                     mem_en, fill_wen, fill_done, fill_sel_d, icache_stall, dcache_stall, dbg_state, mem_addr, fill_word);
        end
        rst_n = 1'b1;
        step();
        checks++;
        if (dbg_state !== 1'b0 || mem_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got st=%b en=%b want st=0 en=0", dbg_state, mem_en);
        end
    endtask

    task automatic test_i_miss();
        logic        e_en, e_wen, e_done;
        logic [15:0] e_addr;
        logic [2:0]  e_word;
        icache_miss = 1'b1; icache_addr = 16'h0036;
        #1;
        checks++;
        if (mem_en !== 1'b0 || icache_stall !== 1'b1) begin
            errors++;
            $display("FAIL i_grant_cycle: got en=%b ist=%b want en=0 ist=1", mem_en, icache_stall);
        end
        for (int k = 1; k <= 12; k++) begin
            step();
            e_en   = (k <= 8);
            e_addr = e_en ? 16'h0030 + 16'(2 * (k - 1)) : 16'h0000;
            e_wen  = (k >= 5);
            e_word = e_wen ? 3'(k - 5) : 3'd0;
            e_done = (k == 12);
            checks++;
            if (mem_en !== e_en || mem_addr !== e_addr) begin
                errors++;
                $display("FAIL i_issue k=%0d: got en=%b addr=%h want en=%b addr=%h", k, mem_en, mem_addr, e_en, e_addr);
            end
            checks++;
            if (fill_wen !== e_wen || fill_word !== e_word || fill_done !== e_done || fill_sel_d !== 1'b0) begin
                errors++;
                $display("FAIL i_return k=%0d: got wen=%b word=%0d done=%b sel=%b want wen=%b word=%0d done=%b sel=0",
                         k, fill_wen, fill_word, fill_done, fill_sel_d, e_wen, e_word, e_done);
            end
            checks++;
            if (icache_stall !== !e_done) begin
                errors++;
                $display("FAIL i_stall k=%0d: got %b want %b", k, icache_stall, !e_done);
            end
        end
        icache_miss = 1'b0;
        step();
        checks++;
        if (dbg_state !== 1'b0 || mem_en !== 1'b0 || fill_wen !== 1'b0) begin
            errors++;
            $display("FAIL i_after: got st=%b en=%b wen=%b want 0 0 0", dbg_state, mem_en, fill_wen);
        end
    endtask

    task automatic test_simultaneous();
        logic        e_en, e_wen, e_done;
        logic [15:0] e_addr;
        icache_miss = 1'b1; icache_addr = 16'h1000;
        dcache_miss = 1'b1; dcache_addr = 16'h2004;
        for (int k = 1; k <= 12; k++) begin
            step();
            e_en   = (k <= 8);
            e_addr = e_en ? 16'h2000 + 16'(2 * (k - 1)) : 16'h0000;
            e_wen  = (k >= 5);
            e_done = (k == 12);
            checks++;
            if (mem_en !== e_en || mem_addr !== e_addr || fill_wen !== e_wen || fill_done !== e_done || fill_sel_d !== 1'b1) begin
                errors++;
                $display("FAIL sim_d k=%0d: got en=%b addr=%h wen=%b done=%b sel=%b want en=%b addr=%h wen=%b done=%b sel=1",
                         k, mem_en, mem_addr, fill_wen, fill_done, fill_sel_d, e_en, e_addr, e_wen, e_done);
            end
            checks++;
            if (icache_stall !== 1'b1 || dcache_stall !== !e_done) begin
                errors++;
                $display("FAIL sim_stalls k=%0d: got ist=%b dst=%b want ist=1 dst=%b", k, icache_stall, dcache_stall, !e_done);
            end
        end
        dcache_miss = 1'b0;
        step();
        checks++;
        if (dbg_state !== 1'b0 || mem_en !== 1'b0 || icache_stall !== 1'b1) begin
            errors++;
            $display("FAIL sim_gap: got st=%b en=%b ist=%b want st=0 en=0 ist=1", dbg_state, mem_en, icache_stall);
        end
        for (int k = 1; k <= 12; k++) begin
            step();
            e_en   = (k <= 8);
            e_addr = e_en ? 16'h1000 + 16'(2 * (k - 1)) : 16'h0000;
            e_wen  = (k >= 5);
            e_done = (k == 12);
            checks++;
            if (mem_en !== e_en || mem_addr !== e_addr || fill_wen !== e_wen || fill_done !== e_done || fill_sel_d !== 1'b0) begin
                errors++;
                $display("FAIL sim_i k=%0d: got en=%b addr=%h wen=%b done=%b sel=%b want en=%b addr=%h wen=%b done=%b sel=0",
                         k, mem_en, mem_addr, fill_wen, fill_done, fill_sel_d, e_en, e_addr, e_wen, e_done);
            end
        end
        icache_miss = 1'b0;
        step();
    endtask

    task automatic test_drop_mid_fill();
        int n_wen;
        int n_done;
        n_wen = 0; n_done = 0;
        icache_miss = 1'b1; icache_addr = 16'h0200;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (fill_wen === 1'b1) n_wen++;
            if (fill_done === 1'b1) n_done++;
            if (k == 3) icache_miss = 1'b0;
        end
        checks++;
        if (n_wen != 8 || n_done != 1) begin
            errors++;
            $display("FAIL drop_fill_count: got wen=%0d done=%0d want wen=8 done=1", n_wen, n_done);
        end
        step();
        checks++;
        if (dbg_state !== 1'b0 || mem_en !== 1'b0 || icache_stall !== 1'b0) begin
            errors++;
            $display("FAIL drop_after: got st=%b en=%b ist=%b want 0 0 0", dbg_state, mem_en, icache_stall);
        end
    endtask

    task automatic test_reset_mid_fill();
        logic        e_en, e_wen, e_done;
        logic [15:0] e_addr;
        logic [2:0]  e_word;
        dcache_miss = 1'b1; dcache_addr = 16'h0408;
        for (int k = 1; k <= 5; k++) step();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({mem_en, fill_wen, fill_done, fill_sel_d, dbg_state} !== 5'b0 || mem_addr !== 16'h0 || fill_word !== 3'd0) begin
            errors++;
            $display("FAIL rst_mid_async: got en=%b wen=%b done=%b sel=%b st=%b addr=%h word=%0d want all 0",
                     mem_en, fill_wen, fill_done, fill_sel_d, dbg_state, mem_addr, fill_word);
        end
        step();
        step();
        checks++;
        if (fill_done !== 1'b0 || dbg_state !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_hold: got done=%b st=%b want 0 0", fill_done, dbg_state);
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            e_en   = (k <= 8);
            e_addr = e_en ? 16'h0400 + 16'(2 * (k - 1)) : 16'h0000;
            e_wen  = (k >= 5);
            e_word = e_wen ? 3'(k - 5) : 3'd0;
            e_done = (k == 12);
            checks++;
            if (mem_en !== e_en || mem_addr !== e_addr || fill_wen !== e_wen || fill_word !== e_word || fill_done !== e_done) begin
                errors++;
                $display("FAIL rst_regrant k=%0d: got en=%b addr=%h wen=%b word=%0d done=%b want en=%b addr=%h wen=%b word=%0d done=%b",
                         k, mem_en, mem_addr, fill_wen, fill_word, fill_done, e_en, e_addr, e_wen, e_word, e_done);
            end
        end
        dcache_miss = 1'b0;
        step();
    endtask

    task automatic test_spurious_valid();
        spur_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (fill_wen !== 1'b0 || fill_done !== 1'b0 || dbg_state !== 1'b0) begin
                errors++;
                $display("FAIL spurious k=%0d: got wen=%b done=%b st=%b want 0 0 0", k, fill_wen, fill_done, dbg_state);
            end
            step();
        end
        spur_valid = 1'b0;
        checks++;
        if (dbg_state !== 1'b0 || mem_en !== 1'b0) begin
            errors++;
            $display("FAIL spurious_after: got st=%b en=%b want 0 0", dbg_state, mem_en);
        end
    endtask

    task automatic test_back_to_back();
        logic        e_en, e_done;
        logic [15:0] e_addr;
        dcache_miss = 1'b1; dcache_addr = 16'h0010;
        for (int k = 1; k <= 12; k++) begin
            step();
            e_en   = (k <= 8);
            e_addr = e_en ? 16'h0010 + 16'(2 * (k - 1)) : 16'h0000;
            e_done = (k == 12);
            checks++;
            if (mem_en !== e_en || mem_addr !== e_addr || fill_done !== e_done) begin
                errors++;
                $display("FAIL b2b_first k=%0d: got en=%b addr=%h done=%b want en=%b addr=%h done=%b",
                         k, mem_en, mem_addr, fill_done, e_en, e_addr, e_done);
            end
            if (k == 12) dcache_addr = 16'h00F0;
        end
        step();
        checks++;
        if (dbg_state !== 1'b0 || mem_en !== 1'b0 || dcache_stall !== 1'b1) begin
            errors++;
            $display("FAIL b2b_grant: got st=%b en=%b dst=%b want st=0 en=0 dst=1", dbg_state, mem_en, dcache_stall);
        end
        for (int k = 1; k <= 12; k++) begin
            step();
            e_en   = (k <= 8);
            e_addr = e_en ? 16'h00F0 + 16'(2 * (k - 1)) : 16'h0000;
            e_done = (k == 12);
            checks++;
            if (mem_en !== e_en || mem_addr !== e_addr || fill_done !== e_done || fill_sel_d !== 1'b1) begin
                errors++;
                $display("FAIL b2b_second k=%0d: got en=%b addr=%h done=%b sel=%b want en=%b addr=%h done=%b sel=1",
                         k, mem_en, mem_addr, fill_done, fill_sel_d, e_en, e_addr, e_done);
            end
        end
        dcache_miss = 1'b0;
        step();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_i_miss();
        test_simultaneous();
        test_drop_mid_fill();
        test_reset_mid_fill();
        test_spurious_valid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
